// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/BIOS memory port arbiter.
// Holds the data width, default memory address width and read-owner encoding.
package imem_port_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int IMEM_ADDR_W = 12;
  localparam int STREAK_W    = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_port_arbiter_streak.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
// at_max tells the arbiter to hand the next slot to fetch.
module arb_streak_counter
  import imem_port_arbiter_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STREAK_W-1:0] MAX_L = STREAK_W'(MAX);
  localparam logic [STREAK_W-1:0] SAT_L = {STREAK_W{1'b1}};

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // Next streak value: clear wins over increment, increment saturates.
  always_comb begin
    streak_d = streak_q;
    if (clr) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (inc && (streak_q != SAT_L)) begin
      streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= {STREAK_W{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

  assign at_max = (streak_q == MAX_L);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous-read IMEM/BIOS port between fetch and the data path.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [XLEN-1:0]   f_addr,
  output logic              f_rvalid,
  output logic [XLEN-1:0]   f_rdata,
  output logic              stallF,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_fstall
`endif
);

  logic   gnt_fetch;
  logic   gnt_data;
  logic   at_max;
  owner_e owner_q;
  owner_e owner_d;

  arb_streak_counter #(
    .MAX(MAX_STREAK)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .inc   (gnt_data & f_req),
    .clr   (gnt_fetch | ~f_req),
    .at_max(at_max)
  );

  // Grant: data by default, fetch once the data streak has reached its limit.
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;
    if (rst) begin
      gnt_fetch = 1'b0;
      gnt_data  = 1'b0;
    end else if (d_req && !(f_req && at_max)) begin
      gnt_data = 1'b1;
    end else if (f_req) begin
      gnt_fetch = 1'b1;
    end else begin
      gnt_fetch = 1'b0;
      gnt_data  = 1'b0;
    end
  end

  // Memory port mux and read-owner selection for the winner.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {XLEN{1'b0}};
    owner_d   = OWN_NONE;
    if (gnt_data) begin
      mem_en   = 1'b1;
      mem_addr = d_addr[ADDR_W+1:2];
      if (d_we) begin
        mem_we    = d_wmask;
        mem_wdata = d_wdata;
      end else begin
        owner_d = OWN_DATA;
      end
    end else if (gnt_fetch) begin
      mem_en   = 1'b1;
      mem_addr = f_addr[ADDR_W+1:2];
      owner_d  = OWN_FETCH;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Remembers who owns the read data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign stallF  = f_req & ~gnt_fetch;
  assign d_stall = d_req & ~gnt_data;

  // rst also masks the read in flight so nothing is delivered during reset.
  assign f_rvalid = (owner_q == OWN_FETCH) && !rst;
  assign d_rvalid = (owner_q == OWN_DATA) && !rst;
  assign f_rdata  = f_rvalid ? mem_rdata : {XLEN{1'b0}};
  assign d_rdata  = d_rvalid ? mem_rdata : {XLEN{1'b0}};

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_fstall_q;

  // Collision and fetch-stall cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= 32'd0;
      perf_fstall_q   <= 32'd0;
    end else begin
      perf_conflict_q <= perf_conflict_q + {31'd0, (f_req & d_req)};
      perf_fstall_q   <= perf_fstall_q + {31'd0, stallF};
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_fstall   = perf_fstall_q;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[XLEN-1:ADDR_W+2], f_addr[1:0],
                              d_addr[XLEN-1:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: a behavioural sync RAM answers the port,
// expected read returns are queued at grant time and popped one cycle later.
module tb_imem_port_arbiter;
  import imem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        f_rvalid, d_rvalid, stallF, d_stall, mem_en;
  logic [31:0] f_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict, perf_fstall;
`endif

  localparam int NONE = 0;
  localparam int GF   = 1;
  localparam int GD   = 2;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] dev_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        mem_init = 1'b1;
  int          checks   = 0;
  int          failures = 0;
  int          conf_cnt = 0;
  int          fst_cnt  = 0;

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .stallF   (stallF),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wmask  (d_wmask),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_fstall  (perf_fstall)
`endif
  );

  function automatic logic [31:0] pat(input int i);
    logic [15:0] w;
    w = i[15:0];
    return {w ^ 16'hA5A5, ~w};
  endfunction

  // Behavioural synchronous-read, byte-writable memory.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) dev_mem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) dev_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= dev_mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the port and the read returned this cycle.
  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] wd, input logic [3:0] wm, input int eg);
    rd_exp_t     e;
    logic [11:0] fw, dwd;
    rst = r; f_req = fr; f_addr = fa; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = wd; d_wmask = wm;
    fw  = fa[13:2];
    dwd = da[13:2];
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : rd_exp_t'{own: 2'd0, data: 32'd0};
    if (r) e.own = 2'd0;
    chk("f_rvalid", 32'(f_rvalid), 32'(e.own == 2'd1));
    chk("f_rdata", f_rdata, (e.own == 2'd1) ? e.data : 32'd0);
    chk("d_rvalid", 32'(d_rvalid), 32'(e.own == 2'd2));
    chk("d_rdata", d_rdata, (e.own == 2'd2) ? e.data : 32'd0);
    chk("stallF", 32'(stallF), 32'(fr && (eg != GF)));
    chk("d_stall", 32'(d_stall), 32'(dr && (eg != GD)));
    chk("mem_en", 32'(mem_en), 32'(eg != NONE));
    chk("mem_we", 32'(mem_we), (eg == GD && dw) ? 32'(wm) : 32'd0);
    chk("mem_addr", 32'(mem_addr), (eg == GF) ? 32'(fw) : (eg == GD) ? 32'(dwd) : 32'd0);
    chk("mem_wdata", mem_wdata, (eg == GD && dw) ? wd : 32'd0);
    if (eg == GF) exp_q.push_back(rd_exp_t'{own: 2'd1, data: ref_mem[fw]});
    else if (eg == GD && !dw) exp_q.push_back(rd_exp_t'{own: 2'd2, data: ref_mem[dwd]});
    else exp_q.push_back(rd_exp_t'{own: 2'd0, data: 32'd0});
    if (eg == GD && dw)
      for (int b = 0; b < 4; b++)
        if (wm[b]) ref_mem[dwd][b*8 +: 8] = wd[b*8 +: 8];
    if (r) begin
      conf_cnt = 0;
      fst_cnt  = 0;
    end else begin
      if (fr && dr) conf_cnt++;
      if (fr && (eg != GF)) fst_cnt++;
    end
    @(posedge clk);
    #1;
    mem_init = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, NONE);
  endtask

  initial begin
    int seq[8];
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    seq = '{GD, GD, GD, GF, GD, GD, GD, GF};

    // Reset beats any request.
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, NONE);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, NONE);
    idle();

    // Fetch alone.
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, GF);
    idle();

    // Collision: data load wins, then held fetch is served.
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, GD);
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, GF);
    idle();

    // Starvation limit with both requests held.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'd0, 4'b0000, seq[i]);
    idle();

    // Partial store, empty-mask store, read-back.
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h44, 32'hDEADBEEF, 4'b0011, GD);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h48, 32'h12345678, 4'b0000, GD);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, 4'b0000, GD);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h48, 32'd0, 4'b0000, GD);
    idle();

    // Random single-requester traffic over a small window of words.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, w;
      logic [3:0]  m;
      int          k;
      a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      w = $urandom;
      m = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 2);
      if (k == 0) step(1'b0, 1'b1, a, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, GF);
      else if (k == 1) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0, 4'b0000, GD);
      else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, a, w, m, GD);
    end
    idle();

    // Reset while a fetch read is in flight.
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, GF);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, NONE);
    idle();

    // Five collision cycles from a fresh streak.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'd0, 4'b0000, seq[i]);
    idle();

`ifdef ARB_PERF_CNT_EN
    chk("perf_conflict", perf_conflict, 32'(conf_cnt));
    chk("perf_fstall", perf_fstall, 32'(fst_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
